pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Owns the architectural PC and fetches instructions from instruction memory.
//   Sits upstream of decode. Sources Pc and IR (IR[25:0]) for the next-PC logic.
//   Commits that logic's pc_in as the new PC when decode accepts the instruction.
//   One instruction is in flight at a time; memory and decode stalls are tolerated.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset; must be word-aligned
//   CNT_W      32              width of retired-instruction counter
// PORTS
//   clk          in   1       single clock, rising edge
//   rst_n        in   1       synchronous, active-low reset
//   halt         in   1       stop issuing fetches; sampled in IDLE and at commit
//   imem_req     out  1       fetch request valid
//   imem_addr    out  32      fetch byte address (= pc)
//   imem_ready   in   1       memory accepts request this cycle
//   imem_rvalid  in   1       read data valid
//   imem_rdata   in   32      instruction word
//   pc           out  32      current PC, to next-PC logic and decode
//   ir           out  32      fetched instruction
//   inst_valid   out  1       ir/pc hold a valid instruction for decode
//   inst_ready   in   1       decode consumes the instruction this cycle
//   pc_in        in   32      next PC from next-PC logic; valid while inst_valid
//   fetch_fault  out  1       sticky; committed pc_in was misaligned
//   inst_count   out  CNT_W   retired-instruction count
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): pc=RESET_PC, ir=0, inst_valid=0, imem_req=0,
//     fetch_fault=0, inst_count=0, state=IDLE. Reset overrides any state,
//     including mid-request. A late imem_rvalid after reset is ignored.
//   States IDLE, REQ, WAIT, HOLD, FAULT:
//   IDLE:  outputs quiet. halt=0 -> REQ next cycle; halt=1 -> stay.
//   REQ:   imem_req=1, imem_addr=pc, held stable until imem_ready=1 -> WAIT.
//   WAIT:  imem_req=0. On imem_rvalid: ir<=imem_rdata, inst_valid<=1 -> HOLD.
//   HOLD:  inst_valid=1; pc and ir are stable.
//     On inst_ready=1 (commit): pc<=pc_in, inst_valid<=0, inst_count+=1 (wraps).
//     After commit: pc_in[1:0]!=0 -> fetch_fault<=1, FAULT;
//     else halt=1 -> IDLE; else -> REQ.
//   FAULT: all request/valid outputs 0; pc holds the faulting value.
//     Only reset exits this state.
//   imem_rvalid is ignored outside WAIT. Memory must not return data in the
//     same cycle it accepts the request.
//   pc_in is sampled only at commit; its value at any other time is don't-care.
//   Throughput: minimum 3 cycles per instruction (REQ accept, rvalid, commit).
//   Back-to-back commits: the REQ for pc_in is issued the cycle after commit.
//   Zero-wait example: commit at cycle N, REQ at N+1, rvalid at N+2, commit at N+3.
//   Misaligned RESET_PC is a configuration error; no runtime check.
// STRUCTURE
//   Shared package cpu_pkg: fetch_state_t enum (IDLE, REQ, WAIT, HOLD, FAULT),
//     INSN_W=32, PC_STEP=4, default RESET_PC constant.
//   Single module, no sub-module; FSM plus PC, IR and counter registers.
// TESTING
//   1 Reset, zero-wait memory, pc_in=pc+4, inst_ready=1: addresses 0,4,8 issued;
//     inst_count=3 after third commit; 3 cycles per instruction.
//   2 imem_ready low 4 cycles in REQ: imem_addr and imem_req stable throughout;
//     no WAIT entry until imem_ready=1.
//   3 inst_ready low 5 cycles in HOLD: ir, pc and inst_valid unchanged;
//     pc_in toggled meanwhile is ignored; the value at commit is loaded.
//   4 Commit with pc_in=32'h0040_0002: fetch_fault=1 and pc=32'h0040_0002;
//     no further imem_req; reset clears the fault.
//   5 halt=1 at commit: IDLE with no request. Deassert halt: REQ to the
//     committed pc the next cycle.
//   6 rst_n=0 during WAIT, then rvalid=1 after release: rvalid ignored;
//     pc=RESET_PC and ir=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
//
// Purpose: state encoding, instruction width, PC step and default reset PC
//          used by the fetch unit and its neighbours.
// Contents: fetch_state_t, INSN_W, PC_STEP, DEFAULT_RESET_PC, pc_is_aligned()
package cpu_pkg;

  localparam int unsigned INSN_W  = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  // A PC is legal only on an instruction boundary (multiple of PC_STEP).
  function automatic logic pc_is_aligned(input logic [31:0] addr);
    logic [31:0] mask;
    mask = 32'(PC_STEP - 1);
    return (addr & mask) == 32'h0;
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC owner and single-outstanding instruction fetch
//
// Purpose: holds the PC, fetches one instruction at a time from instruction
//          memory, presents it to decode, and commits the next-PC value when
//          decode accepts. A misaligned committed PC latches a sticky fault and
//          parks the unit until reset.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   halt                       stop issuing fetches (sampled in IDLE and at commit)
//   imem_req/imem_addr         fetch request and byte address (= pc)
//   imem_ready                 memory accepts the request
//   imem_rvalid/imem_rdata     returned instruction word
//   pc/ir/inst_valid           instruction presented to decode
//   inst_ready                 decode consumes the instruction (commit)
//   pc_in                      next PC from next-PC logic, sampled at commit
//   fetch_fault                sticky misaligned-PC flag
//   inst_count                 retired-instruction counter (wraps)
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [31:0]       pc,
  output logic [INSN_W-1:0] ir,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic [31:0]       pc_in,
  output logic              fetch_fault,
  output logic [CNT_W-1:0]  inst_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!halt) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Data is only meaningful here; rvalid in any other state is stale.
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          pc_d  = pc_in;
          cnt_d = cnt_q + CNT_ONE;
          // The faulting PC is still committed so software can see where it went.
          if (!pc_is_aligned(pc_in)) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else if (halt) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign inst_valid  = (state_q == ST_HOLD);
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign fetch_fault = fault_q;
  assign inst_count  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        fetch_fault;
  logic [31:0] inst_count;

  pc_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .ir(ir), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc_in(pc_in), .fetch_fault(fetch_fault), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned mem_wait;
    int unsigned dec_wait;
    logic [31:0] pc_in;
    logic [31:0] exp_addr;
    bit          chk_tp;
    bit          halt_at_commit;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } sb_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;
  int   last_req_cyc = 0;
  vec_t vecs[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(imem_req), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; halt = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", ir, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_count", inst_count, 32'd0);
    exp_count = 0;
    sb_q.delete();
    rst_n = 1'b1;
  endtask

  // One full instruction: request (with memory stall), data return,
  // decode stall, then commit of v.pc_in.
  task automatic fetch_one(input vec_t v);
    logic [31:0] a;
    sb_t e;
    wait_req("req_seen");
    if (v.chk_tp) chk("cycles_per_insn", 32'(cyc - last_req_cyc), 32'd3);
    last_req_cyc = cyc;
    chk("req_addr", imem_addr, v.exp_addr);
    a = v.exp_addr;
    for (int i = 0; i < int'(v.mem_wait); i++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      chk("req_stall_req", 32'(imem_req), 32'd1);
      chk("req_stall_addr", imem_addr, a);
    end
    imem_ready = 1'b1;
    sb_q.push_back('{pc: a, ir: mem_word(a)});
    @(negedge clk);
    imem_ready = 1'b0;
    chk("wait_req_low", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(a);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("hold_valid", 32'(inst_valid), 32'd1);
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty: got 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < int'(v.dec_wait); i++) begin
      pc_in = $urandom;
      inst_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_pc", pc, e.pc);
      chk("stall_ir", ir, e.ir);
    end
    chk("sb_pc", pc, e.pc);
    chk("sb_ir", ir, e.ir);
    pc_in = v.pc_in;
    halt  = v.halt_at_commit;
    inst_ready = 1'b1;
    exp_count++;
    @(negedge clk);
    inst_ready = 1'b0;
    pc_in = $urandom;
    chk("commit_pc", pc, v.pc_in);
    chk("commit_count", inst_count, 32'(exp_count));
    chk("commit_valid", 32'(inst_valid), 32'd0);
  endtask

  initial begin
    vec_t hv;
    //          mem  dec  pc_in          exp_addr       tp  halt
    vecs[0] = '{0,   0,   32'h0000_0004, 32'h0000_0000, 0,  0};
    vecs[1] = '{0,   0,   32'h0000_0008, 32'h0000_0004, 1,  0};
    vecs[2] = '{0,   0,   32'h0000_000C, 32'h0000_0008, 1,  0};
    vecs[3] = '{4,   0,   32'h0000_0100, 32'h0000_000C, 0,  0};
    vecs[4] = '{0,   5,   32'h0000_2000, 32'h0000_0100, 0,  0};
    vecs[5] = '{2,   3,   32'hFFFF_FFFC, 32'h0000_2000, 0,  0};
    vecs[6] = '{1,   1,   32'h0000_0010, 32'hFFFF_FFFC, 0,  0};

    do_reset();
    for (int k = 0; k < 7; k++) begin
      fetch_one(vecs[k]);
      if (k == 2) chk("count_after_three", inst_count, 32'd3);
    end

    // halt at commit: parks in IDLE, resumes at the committed pc.
    hv = '{0, 0, 32'h0000_3000, 32'h0000_0010, 0, 1};
    fetch_one(hv);
    for (int i = 0; i < 3; i++) begin
      chk("halt_no_req", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    halt = 1'b0;
    @(negedge clk);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h0000_3000);

    // Misaligned commit: sticky fault, pc holds faulting value, no more fetches.
    hv = '{0, 0, 32'h0040_0002, 32'h0000_3000, 0, 0};
    fetch_one(hv);
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_pc", pc, 32'h0040_0002);
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1'b1;
      imem_rvalid = 1'b1;
      @(negedge clk);
      chk("fault_no_req", 32'(imem_req), 32'd0);
      chk("fault_no_valid", 32'(inst_valid), 32'd0);
      chk("fault_sticky", 32'(fetch_fault), 32'd1);
    end
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    do_reset();
    @(negedge clk);
    chk("fault_cleared", 32'(fetch_fault), 32'd0);

    // Reset during WAIT, then a late rvalid must be ignored.
    wait_req("req_before_wait_rst");
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("late_rvalid_valid", 32'(inst_valid), 32'd0);
    chk("late_rvalid_ir", ir, 32'h0);
    chk("late_rvalid_pc", pc, RST_PC);
    chk("late_rvalid_req", 32'(imem_req), 32'd1);
    exp_count = 0;
    sb_q.delete();
    hv = '{0, 0, 32'h0000_0004, RST_PC, 0, 0};
    fetch_one(hv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
